// File: rtl/multicycle_core_pkg.sv
// Shared definitions for the multicycle core: FSM states, ALU operations and
// the instruction encodings the core recognises.
package multicycle_core_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_ORR = 2'd3
    } alu_op_e;

    localparam logic [10:0] OP_ADD    = 11'b10001011000;
    localparam logic [10:0] OP_SUB    = 11'b11001011000;
    localparam logic [10:0] OP_AND    = 11'b10001010000;
    localparam logic [10:0] OP_ORR    = 11'b10101010000;
    localparam logic [10:0] OP_LDUR   = 11'b11111000010;
    localparam logic [10:0] OP_STUR   = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ    = 8'b10110100;
    localparam logic [5:0]  OP_B      = 6'b000101;
    localparam logic [31:0] INSN_HALT = 32'h0000_0000;
    localparam logic [4:0]  REG_XZR   = 5'd31;

    function automatic alu_op_e alu_op_of(input logic [10:0] opc);
        case (opc)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_ORR:  return ALU_ORR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file; index 31 is the zero register and
// ignores writes. Reads are combinational, the write lands on the clock edge.
module regfile_2r1w
    import multicycle_core_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [4:0]      raddr_b,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] regs_r [NREG];

    // Register storage: cleared on reset, XZR writes dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (we && (waddr != REG_XZR) && (int'(waddr) < NREG)) begin
            regs_r[waddr] <= wdata;
        end
    end

    // Read ports: XZR and out-of-range indices return zero.
    always_comb begin
        rdata_a = {XLEN{1'b0}};
        rdata_b = {XLEN{1'b0}};
        if ((raddr_a != REG_XZR) && (int'(raddr_a) < NREG)) begin
            rdata_a = regs_r[raddr_a];
        end else begin
            rdata_a = {XLEN{1'b0}};
        end
        if ((raddr_b != REG_XZR) && (int'(raddr_b) < NREG)) begin
            rdata_b = regs_r[raddr_b];
        end else begin
            rdata_b = {XLEN{1'b0}};
        end
    end

endmodule

// File: rtl/multicycle_core.sv
// Non-pipelined LEGv8-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT state machine
// with separate instruction and data request/ready ports.
module multicycle_core
    import multicycle_core_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              NREG     = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            halted,
    output logic            retire,
    output logic [XLEN-1:0] instret
);

    state_e          state_r, state_s;
    logic [XLEN-1:0] pc_r, pc_s, a_r, a_s, b_r, b_s, res_r, res_s, instret_r;
    logic [31:0]     ir_r, ir_s;
    logic            retire_r, retire_s, rf_we;
    logic [XLEN-1:0] rdata_a, rdata_b, alu_res, pc_plus4, mem_off, cbz_off, b_off;
    logic [4:0]      rsel_b;
    logic            is_rtype, is_ldur, is_stur, is_cbz, is_b, is_halt;

    assign pc_plus4 = pc_r + XLEN'(32'd4);
    assign mem_off  = {{(XLEN-9){ir_r[20]}}, ir_r[20:12]};
    assign cbz_off  = {{(XLEN-21){ir_r[23]}}, ir_r[23:5], 2'b00};
    assign b_off    = {{(XLEN-28){ir_r[25]}}, ir_r[25:0], 2'b00};
    assign rsel_b   = is_rtype ? ir_r[20:16] : ir_r[4:0];

    // Instruction class decode from the latched IR.
    always_comb begin
        is_halt  = (ir_r == INSN_HALT);
        is_rtype = (ir_r[31:21] == OP_ADD) || (ir_r[31:21] == OP_SUB) ||
                   (ir_r[31:21] == OP_AND) || (ir_r[31:21] == OP_ORR);
        is_ldur  = (ir_r[31:21] == OP_LDUR);
        is_stur  = (ir_r[31:21] == OP_STUR);
        is_cbz   = (ir_r[31:24] == OP_CBZ);
        is_b     = (ir_r[31:26] == OP_B);
    end

    // ALU for the R-type group.
    always_comb begin
        case (alu_op_of(ir_r[31:21]))
            ALU_ADD: alu_res = a_r + b_r;
            ALU_SUB: alu_res = a_r - b_r;
            ALU_AND: alu_res = a_r & b_r;
            ALU_ORR: alu_res = a_r | b_r;
            default: alu_res = a_r + b_r;
        endcase
    end

    regfile_2r1w #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (ir_r[4:0]),
        .wdata   (res_r),
        .raddr_a (ir_r[9:5]),
        .rdata_a (rdata_a),
        .raddr_b (rsel_b),
        .rdata_b (rdata_b)
    );

    // Next-state and datapath latch control.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        ir_s     = ir_r;
        a_s      = a_r;
        b_s      = b_r;
        res_s    = res_r;
        retire_s = 1'b0;
        rf_we    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (imem_ready) begin
                    ir_s    = imem_rdata;
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                a_s     = rdata_a;
                b_s     = rdata_b;
                state_s = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_halt) begin
                    retire_s = 1'b1;
                    state_s  = ST_HALT;
                end else if (is_rtype) begin
                    res_s   = alu_res;
                    state_s = ST_WB;
                end else if (is_ldur || is_stur) begin
                    res_s   = a_r + mem_off;
                    state_s = ST_MEM;
                end else if (is_cbz) begin
                    pc_s     = (b_r == {XLEN{1'b0}}) ? (pc_r + cbz_off) : pc_plus4;
                    retire_s = 1'b1;
                    state_s  = ST_FETCH;
                end else if (is_b) begin
                    pc_s     = pc_r + b_off;
                    retire_s = 1'b1;
                    state_s  = ST_FETCH;
                end else begin
                    pc_s     = pc_plus4;
                    retire_s = 1'b1;
                    state_s  = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    if (is_stur) begin
                        pc_s     = pc_plus4;
                        retire_s = 1'b1;
                        state_s  = ST_FETCH;
                    end else begin
                        res_s   = dmem_rdata;
                        state_s = ST_WB;
                    end
                end else begin
                    state_s = ST_MEM;
                end
            end
            ST_WB: begin
                rf_we    = (ir_r[4:0] != REG_XZR);
                pc_s     = pc_plus4;
                retire_s = 1'b1;
                state_s  = ST_FETCH;
            end
            ST_HALT: begin
                state_s = ST_HALT;
            end
            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    // State, PC, latches and retire bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_FETCH;
            pc_r      <= RESET_PC;
            ir_r      <= 32'h0000_0000;
            a_r       <= {XLEN{1'b0}};
            b_r       <= {XLEN{1'b0}};
            res_r     <= {XLEN{1'b0}};
            retire_r  <= 1'b0;
            instret_r <= {XLEN{1'b0}};
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            ir_r     <= ir_s;
            a_r      <= a_s;
            b_r      <= b_s;
            res_r    <= res_s;
            retire_r <= retire_s;
            if (retire_s) begin
                instret_r <= instret_r + XLEN'(32'd1);
            end else begin
                instret_r <= instret_r;
            end
        end
    end

    // Requests are masked while reset is held so an in-flight access drops at once.
    assign imem_req   = (state_r == ST_FETCH) && !reset;
    assign dmem_req   = (state_r == ST_MEM) && !reset;
    assign imem_addr  = pc_r;
    assign dmem_we    = is_stur;
    assign dmem_addr  = res_r;
    assign dmem_wdata = b_r;
    assign halted     = (state_r == ST_HALT);
    assign retire     = retire_r;
    assign instret    = instret_r;

endmodule
